muldiv_ctrl: RTL and testbench

Sequenced signed multiply/divide unit owning the HI and LO registers of the multicycle MIPS datapath. `ctrl_unit` issues a one-cycle `start` with the operation and the A/B register values, then stalls until `done`. The block then exposes HI/LO to the write-data path for MFHI/MFLO. It replaces a combinational multiplier with a 32-iteration shift-add / restoring-divide sequencer.

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_ctrl_if.sv | 27 ++
 rtl/muldiv_ctrl.sv | 159 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequenced multiply/divide unit: FSM states,
// operation encodings and the iteration count.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int ITER  = 32;
  localparam int CNT_W = 6;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Request/result bundle between the control unit (master) and the
// multiply/divide sequencer (slave).
interface muldiv_ctrl_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/muldiv_ctrl.sv
// 32-iteration shift-add multiplier / restoring divider that owns HI and LO.
// Works on operand magnitudes; signs are applied in the FIX state.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_ctrl_if.slave bus
);

  state_t               state_reg;
  state_t               state_next;
  logic                 op_reg;
  logic                 sign_a_reg;
  logic                 sign_b_reg;
  logic                 div_zero_reg;
  logic [WIDTH-1:0]     opnd_a_reg;
  logic [WIDTH-1:0]     opnd_b_reg;
  logic [WIDTH-1:0]     hi_reg;
  logic [WIDTH-1:0]     lo_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [CNT_W-1:0]     cnt_reg;

  logic                 start_div_zero;
  logic                 last_iter;
  logic                 sub;
  logic                 q_bit;
  logic [WIDTH:0]       add_x;
  logic [WIDTH:0]       add_y;
  logic [WIDTH:0]       add_sum;
  logic [2*WIDTH-1:0]   acc_step;
  logic [2*WIDTH-1:0]   prod_signed;
  logic [WIDTH-1:0]     quot_signed;
  logic [WIDTH-1:0]     rem_signed;

  // Unsigned magnitude: the most negative value maps onto itself.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  assign start_div_zero = (bus.op == OP_DIV) && (bus.b == '0);
  assign last_iter      = (cnt_reg == CNT_W'(ITER - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = start_div_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One adder serves both operations: MULT adds the multiplicand into the
  // upper half, DIV trial-subtracts the divisor from the shifted remainder.
  always_comb begin
    sub   = 1'b0;
    add_x = {1'b0, acc_reg[2*WIDTH-1:WIDTH]};
    add_y = opnd_b_reg[0] ? {1'b0, opnd_a_reg} : '0;
    if (op_reg == OP_DIV) begin
      sub   = 1'b1;
      add_x = {acc_reg[2*WIDTH-2:WIDTH], opnd_a_reg[WIDTH-1]};
      add_y = {1'b0, opnd_b_reg};
    end
    add_sum = add_x + (sub ? ~add_y : add_y) + {{WIDTH{1'b0}}, sub};
  end

  always_comb begin
    q_bit = ~add_sum[WIDTH];
    if (op_reg == OP_DIV) begin
      acc_step = {(q_bit ? add_sum[WIDTH-1:0] : add_x[WIDTH-1:0]),
                  acc_reg[WIDTH-2:0], q_bit};
    end else begin
      acc_step = {add_sum, acc_reg[WIDTH-1:1]};
    end
  end

  assign prod_signed = (sign_a_reg ^ sign_b_reg) ? -acc_reg : acc_reg;
  assign quot_signed = (sign_a_reg ^ sign_b_reg) ? -acc_reg[WIDTH-1:0]
                                                 : acc_reg[WIDTH-1:0];
  assign rem_signed  = sign_a_reg ? -acc_reg[2*WIDTH-1:WIDTH]
                                  : acc_reg[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_reg       <= OP_MULT;
      sign_a_reg   <= 1'b0;
      sign_b_reg   <= 1'b0;
      div_zero_reg <= 1'b0;
      opnd_a_reg   <= '0;
      opnd_b_reg   <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
    end else begin
      div_zero_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            div_zero_reg <= start_div_zero;
            op_reg       <= bus.op;
            sign_a_reg   <= bus.a[WIDTH-1];
            sign_b_reg   <= bus.b[WIDTH-1];
            opnd_a_reg   <= magnitude(bus.a);
            opnd_b_reg   <= magnitude(bus.b);
            acc_reg      <= '0;
            cnt_reg      <= '0;
          end
        end
        RUN: begin
          acc_reg <= acc_step;
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (op_reg == OP_DIV) begin
            opnd_a_reg <= opnd_a_reg << 1;
          end else begin
            opnd_b_reg <= opnd_b_reg >> 1;
          end
        end
        FIX: begin
          if (op_reg == OP_DIV) begin
            hi_reg <= rem_signed;
            lo_reg <= quot_signed;
          end else begin
            hi_reg <= prod_signed[2*WIDTH-1:WIDTH];
            lo_reg <= prod_signed[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state_reg != IDLE);
  assign bus.done     = (state_reg == DONE);
  assign bus.div_zero = div_zero_reg;
  assign bus.hi       = hi_reg;
  assign bus.lo       = lo_reg;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: hand-computed MULT/DIV results, done/busy
// timing, divide-by-zero, ignored restart and asynchronous reset mid-operation.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;
  logic [31:0] prev_hi;
  logic [31:0] prev_lo;

  muldiv_ctrl_if #(.WIDTH(32)) bus ();

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and follow it to completion. k counts negedges after
  // E0, so done is expected at k = 33 (normal) or k = 0 (divide by zero).
  task automatic run_op(input string tag, input logic op_i,
                        input logic [31:0] a_i, input logic [31:0] b_i,
                        input int exp_k, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dz,
                        input int repulse_at);
    int k;
    bit seen;
    bit busy_ok;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op_i;
    bus.a     = a_i;
    bus.b     = b_i;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = ~op_i;
    bus.a     = 32'hDEAD_BEEF;
    bus.b     = 32'h0000_0007;
    k = 0;
    seen = 1'b0;
    busy_ok = 1'b1;
    while (!seen && k < 60) begin
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (!bus.busy) busy_ok = 1'b0;
        if (k == 16) begin
          check({tag, " hi_hold"}, 64'(bus.hi), 64'(prev_hi));
          check({tag, " lo_hold"}, 64'(bus.lo), 64'(prev_lo));
        end
        if (k == repulse_at - 1) begin
          bus.start = 1'b1;
          bus.op    = OP_DIV;
          bus.a     = 32'd9;
          bus.b     = 32'd9;
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
        k++;
      end
    end
    check({tag, " done_seen"}, 64'(seen), 64'(1));
    check({tag, " done_cycle"}, 64'(k), 64'(exp_k));
    check({tag, " busy_run"}, 64'(busy_ok), 64'(1));
    check({tag, " busy_done"}, 64'(bus.busy), 64'(1));
    check({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
    check({tag, " div_zero"}, 64'(bus.div_zero), 64'(exp_dz));
    @(negedge clk);
    check({tag, " done_pulse"}, 64'(bus.done), 64'(0));
    check({tag, " busy_after"}, 64'(bus.busy), 64'(0));
    check({tag, " dz_after"}, 64'(bus.div_zero), 64'(0));
    $display("[TB] %s a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h dz=%0d done@%0d",
             tag, a_i, b_i, bus.hi, bus.lo, exp_dz, k);
    prev_hi = exp_hi;
    prev_lo = exp_lo;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    prev_hi      = 32'h0;
    prev_lo      = 32'h0;
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.op       = OP_MULT;
    bus.a        = 32'h0;
    bus.b        = 32'h0;
    repeat (3) @(negedge clk);
    check("rst busy", 64'(bus.busy), 64'(0));
    check("rst done", 64'(bus.done), 64'(0));
    check("rst div_zero", 64'(bus.div_zero), 64'(0));
    check("rst hi", 64'(bus.hi), 64'(0));
    check("rst lo", 64'(bus.lo), 64'(0));
    reset = 1'b1;

    run_op("mult 7*-3", OP_MULT, 32'd7, 32'hFFFF_FFFD, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, -1);
    run_op("mult min*min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, 32'h0, 1'b0, -1);
    run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, -1);
    run_op("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000, 1'b0, -1);
    run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 33, 32'h1, 32'hFFFF_FFFD, 1'b0, -1);
    run_op("div preload", OP_DIV, 32'h0ACF_1234, 32'h0000_2000, 33, 32'h1234, 32'h5678, 1'b0, -1);
    run_op("div 5/0", OP_DIV, 32'd5, 32'd0, 0, 32'h1234, 32'h5678, 1'b1, -1);
    run_op("mult restart", OP_MULT, 32'd100, 32'hFFFF_FFFB, 33, 32'hFFFF_FFFF, 32'hFFFF_FE0C, 1'b0, 10);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_MULT;
    bus.a     = 32'h0001_2345;
    bus.b     = 32'h0000_0678;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst busy", 64'(bus.busy), 64'(0));
    check("midrst done", 64'(bus.done), 64'(0));
    check("midrst div_zero", 64'(bus.div_zero), 64'(0));
    check("midrst hi", 64'(bus.hi), 64'(0));
    check("midrst lo", 64'(bus.lo), 64'(0));
    $display("[TB] reset mid-mult -> busy=%0d hi=0x%08h lo=0x%08h", bus.busy, bus.hi, bus.lo);
    reset   = 1'b1;
    prev_hi = 32'h0;
    prev_lo = 32'h0;

    run_op("mult 3*4", OP_MULT, 32'd3, 32'd4, 33, 32'h0, 32'd12, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
